// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl : 5-stage MIPS hazard sequencer (load-use, branch, MDU)
// Optional perf counters under HAZARD_PERF_EN.   Rev 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 4,
    parameter int PERF_W  = 32
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              ID_EX_MemRead,
    input  logic [4:0]        ID_EX_Rt,
    input  logic [4:0]        IF_ID_Rs,
    input  logic [4:0]        IF_ID_Rt,
    input  logic              IF_ID_UsesRt,
    input  logic              Branch_Taken,
    input  logic              Mdu_Start_ID,
    input  logic              Hilo_Use_ID,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Bubble,
    output logic              ID_EX_Flush,
    output logic              EX_MEM_Flush,
    output logic              Mdu_Busy,
    output logic [PERF_W-1:0] Stall_Cycles,
    output logic [PERF_W-1:0] Flush_Count
);

    localparam logic [0:0]       S_RUN      = 1'b0;
    localparam logic [0:0]       S_MDU_BUSY = 1'b1;
    localparam logic [CNT_W-1:0] c_lat      = CNT_W'(MDU_LAT);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic [0:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             w_lu_haz, w_mdu_haz;

    assign w_lu_haz  = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                       ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));
    assign w_mdu_haz = (r_state == S_MDU_BUSY) && Hilo_Use_ID;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_RUN;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            S_RUN: begin
                // The op only occupies the unit once it actually leaves ID.
                if (Mdu_Start_ID && !Branch_Taken && !w_lu_haz) begin
                    w_state_nxt = S_MDU_BUSY;
                    w_count_nxt = c_lat;
                end
            end
            S_MDU_BUSY: begin
                // count==MDU_LAT means the op is still in EX, younger than the branch.
                if ((Branch_Taken && (r_count == c_lat)) || (r_count == c_one)) begin
                    w_state_nxt = S_RUN;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count - c_one;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_count_nxt = '0;
            end
        endcase
    end

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        Mdu_Busy     = (r_state == S_MDU_BUSY);
        if (Branch_Taken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
        end else if (w_mdu_haz || w_lu_haz) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!PCWrite && (r_stall_cnt != {PERF_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            if (Branch_Taken && (r_flush_cnt != {PERF_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + PERF_W'(1);
        end
    end

    assign Stall_Cycles = r_stall_cnt;
    assign Flush_Count  = r_flush_cnt;
`else
    assign Stall_Cycles = '0;
    assign Flush_Count  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipeline_hazard_ctrl : directed self-checking bench for pipeline_hazard_ctrl
// Rev 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic        Clk;
    logic        Reset_n;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_Rt;
    logic [4:0]  IF_ID_Rs;
    logic [4:0]  IF_ID_Rt;
    logic        IF_ID_UsesRt;
    logic        Branch_Taken;
    logic        Mdu_Start_ID;
    logic        Hilo_Use_ID;
    logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble;
    logic        ID_EX_Flush, EX_MEM_Flush, Mdu_Busy;
    logic [31:0] Stall_Cycles, Flush_Count;

    int n_checks = 0;
    int n_fail   = 0;

    // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Flush, EX_MEM_Flush, Mdu_Busy}
    logic [6:0] ctrl;
    assign ctrl = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Flush, EX_MEM_Flush, Mdu_Busy};

    localparam logic [6:0] RUN     = 7'b1100000;
    localparam logic [6:0] BUSY    = 7'b1100001;
    localparam logic [6:0] STALL   = 7'b0001000;
    localparam logic [6:0] STALL_B = 7'b0001001;
    localparam logic [6:0] FLUSH   = 7'b1110110;
    localparam logic [6:0] FLUSH_B = 7'b1110111;

`ifdef HAZARD_PERF_EN
    localparam int EXP_STALLS  = 6;
    localparam int EXP_FLUSHES = 4;
`else
    localparam int EXP_STALLS  = 0;
    localparam int EXP_FLUSHES = 0;
`endif

    pipeline_hazard_ctrl #(.MDU_LAT(4), .CNT_W(4), .PERF_W(32)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .ID_EX_MemRead (ID_EX_MemRead),
        .ID_EX_Rt      (ID_EX_Rt),
        .IF_ID_Rs      (IF_ID_Rs),
        .IF_ID_Rt      (IF_ID_Rt),
        .IF_ID_UsesRt  (IF_ID_UsesRt),
        .Branch_Taken  (Branch_Taken),
        .Mdu_Start_ID  (Mdu_Start_ID),
        .Hilo_Use_ID   (Hilo_Use_ID),
        .PCWrite       (PCWrite),
        .IF_ID_Write   (IF_ID_Write),
        .IF_ID_Flush   (IF_ID_Flush),
        .ID_EX_Bubble  (ID_EX_Bubble),
        .ID_EX_Flush   (ID_EX_Flush),
        .EX_MEM_Flush  (EX_MEM_Flush),
        .Mdu_Busy      (Mdu_Busy),
        .Stall_Cycles  (Stall_Cycles),
        .Flush_Count   (Flush_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic idle();
        ID_EX_MemRead = 1'b0;
        ID_EX_Rt      = 5'd0;
        IF_ID_Rs      = 5'd0;
        IF_ID_Rt      = 5'd0;
        IF_ID_UsesRt  = 1'b0;
        Branch_Taken  = 1'b0;
        Mdu_Start_ID  = 1'b0;
        Hilo_Use_ID   = 1'b0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        idle();
        #2;
        n_checks++;
        if (ctrl !== RUN) begin
            n_fail++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, RUN);
        end
        n_checks++;
        if (Stall_Cycles !== 32'd0 || Flush_Count !== 32'd0) begin
            n_fail++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", Stall_Cycles, Flush_Count);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        step();
    endtask

    task automatic test_load_use();
        ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd8;
        #1;
        n_checks++;
        if (ctrl !== STALL) begin
            n_fail++; $display("FAIL lu_rs_stall got=%b exp=%b", ctrl, STALL);
        end
        step();
        ID_EX_MemRead = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== RUN) begin
            n_fail++; $display("FAIL lu_release got=%b exp=%b", ctrl, RUN);
        end
        step();
        ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd5; IF_ID_Rs = 5'd3; IF_ID_Rt = 5'd5; IF_ID_UsesRt = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== STALL) begin
            n_fail++; $display("FAIL lu_rt_stall got=%b exp=%b", ctrl, STALL);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_no_hazard();
        ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0;
        #1;
        n_checks++;
        if (ctrl !== RUN) begin
            n_fail++; $display("FAIL lu_r0 got=%b exp=%b", ctrl, RUN);
        end
        ID_EX_Rt = 5'd9; IF_ID_Rs = 5'd1; IF_ID_Rt = 5'd9; IF_ID_UsesRt = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== RUN) begin
            n_fail++; $display("FAIL lu_rt_unused got=%b exp=%b", ctrl, RUN);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_mdu();
        logic [6:0] exp_seq [4];
        exp_seq = '{BUSY, STALL_B, STALL_B, STALL_B};
        Mdu_Start_ID = 1'b1; Hilo_Use_ID = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== RUN) begin
            n_fail++; $display("FAIL mdu_issue got=%b exp=%b", ctrl, RUN);
        end
        step();
        Mdu_Start_ID = 1'b0; Hilo_Use_ID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i >= 1) Hilo_Use_ID = 1'b1;
            #1;
            n_checks++;
            if (ctrl !== exp_seq[i]) begin
                n_fail++; $display("FAIL mdu_cycle%0d got=%b exp=%b", i + 1, ctrl, exp_seq[i]);
            end
            step();
        end
        #1;
        n_checks++;
        if (ctrl !== RUN) begin
            n_fail++; $display("FAIL mdu_release got=%b exp=%b", ctrl, RUN);
        end
        idle();
        step();
        // mult held in ID by a load-use stall must not start the unit yet
        ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd4; IF_ID_Rs = 5'd4;
        Mdu_Start_ID = 1'b1; Hilo_Use_ID = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== STALL) begin
            n_fail++; $display("FAIL mdu_lu_stall got=%b exp=%b", ctrl, STALL);
        end
        step();
        ID_EX_MemRead = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== RUN) begin
            n_fail++; $display("FAIL mdu_after_lu got=%b exp=%b", ctrl, RUN);
        end
        step();
        idle();
        #1;
        n_checks++;
        if (ctrl !== BUSY) begin
            n_fail++; $display("FAIL mdu_late_entry got=%b exp=%b", ctrl, BUSY);
        end
        repeat (4) step();
        n_checks++;
        if (ctrl !== RUN) begin
            n_fail++; $display("FAIL mdu_late_done got=%b exp=%b", ctrl, RUN);
        end
    endtask

    task automatic test_branch_priority();
        Branch_Taken = 1'b1;
        ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd7; IF_ID_Rs = 5'd7;
        #1;
        n_checks++;
        if (ctrl !== FLUSH) begin
            n_fail++; $display("FAIL br_over_lu got=%b exp=%b", ctrl, FLUSH);
        end
        step();
        idle();
        Branch_Taken = 1'b1; Mdu_Start_ID = 1'b1; Hilo_Use_ID = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== FLUSH) begin
            n_fail++; $display("FAIL br_kill_mdu got=%b exp=%b", ctrl, FLUSH);
        end
        step();
        idle();
        #1;
        n_checks++;
        if (ctrl !== RUN) begin
            n_fail++; $display("FAIL br_no_busy got=%b exp=%b", ctrl, RUN);
        end
        step();
    endtask

    task automatic test_branch_mdu();
        Mdu_Start_ID = 1'b1;
        step();
        Mdu_Start_ID = 1'b0; Branch_Taken = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== FLUSH_B) begin
            n_fail++; $display("FAIL br_busy1 got=%b exp=%b", ctrl, FLUSH_B);
        end
        step();
        Branch_Taken = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== RUN) begin
            n_fail++; $display("FAIL br_abort got=%b exp=%b", ctrl, RUN);
        end
        Mdu_Start_ID = 1'b1;
        step();
        Mdu_Start_ID = 1'b0;
        step();
        step();
        Branch_Taken = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== FLUSH_B) begin
            n_fail++; $display("FAIL br_busy3 got=%b exp=%b", ctrl, FLUSH_B);
        end
        step();
        Branch_Taken = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== BUSY) begin
            n_fail++; $display("FAIL br_busy4 got=%b exp=%b", ctrl, BUSY);
        end
        step();
        n_checks++;
        if (ctrl !== RUN) begin
            n_fail++; $display("FAIL br_busy_done got=%b exp=%b", ctrl, RUN);
        end
    endtask

    task automatic test_perf();
        n_checks++;
        if (Stall_Cycles !== 32'(EXP_STALLS)) begin
            n_fail++; $display("FAIL perf_stalls got=%0d exp=%0d", Stall_Cycles, EXP_STALLS);
        end
        n_checks++;
        if (Flush_Count !== 32'(EXP_FLUSHES)) begin
            n_fail++; $display("FAIL perf_flushes got=%0d exp=%0d", Flush_Count, EXP_FLUSHES);
        end
    endtask

    task automatic test_reset_mid_busy();
        Mdu_Start_ID = 1'b1;
        step();
        Mdu_Start_ID = 1'b0;
        step();
        step();
        #1;
        n_checks++;
        if (ctrl !== BUSY) begin
            n_fail++; $display("FAIL rst_pre_busy got=%b exp=%b", ctrl, BUSY);
        end
        #1;
        Reset_n = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== RUN) begin
            n_fail++; $display("FAIL rst_async_ctrl got=%b exp=%b", ctrl, RUN);
        end
        n_checks++;
        if (Stall_Cycles !== 32'd0 || Flush_Count !== 32'd0) begin
            n_fail++; $display("FAIL rst_async_perf got=%0d/%0d exp=0/0", Stall_Cycles, Flush_Count);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        step();
        n_checks++;
        if (ctrl !== RUN) begin
            n_fail++; $display("FAIL rst_after got=%b exp=%b", ctrl, RUN);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_mdu();
        test_branch_priority();
        test_branch_mdu();
        test_perf();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
